// File: rtl/mult_pkg.sv
// Shared sizing helpers for the Baugh-Wooley multiplier pipeline.
// The finder datapath uses lat() to align its side pipelines with the multiplier.
package mult_pkg;

   function automatic int clog2(input int v);
      int r;
      int p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p * 2;
         r = r + 1;
      end
      return r;
   endfunction

   // Partial-product row count: the shorter extended operand is the multiplier.
   function automatic int n_rows(input int aw, input int bw);
      return ((aw + 1) < (bw + 1)) ? (aw + 1) : (bw + 1);
   endfunction

   function automatic int lat(input int aw, input int bw);
      return clog2(n_rows(aw, bw)) + 2;
   endfunction

   function automatic int rows_at(input int s, input int k);
      return (s + (1 << k) - 1) >> k;
   endfunction

   // Index of the first row of tree layer k in the flattened row store.
   function automatic int row_off(input int s, input int k);
      int r;
      r = 0;
      for (int m = 0; m < k; m++) r = r + rows_at(s, m);
      return r;
   endfunction

   localparam int LAT_24X24 = lat(24, 24);

endpackage

// File: rtl/mult_bw_pp_gen.sv
// Combinational modified Baugh-Wooley partial-product generator.
// Rows are unshifted; row i carries weight 2^i and the adder tree applies the shifts.
module mult_bw_pp_gen
   import mult_pkg::*;
#(
   parameter int AE = 25,
   parameter int BE = 25,
   localparam int S  = (AE < BE) ? AE : BE,
   localparam int LW = (AE < BE) ? BE : AE,
   localparam int W  = AE + BE
) (
   input  logic [AE-1:0]       i_a,
   input  logic [BE-1:0]       i_b,
   output logic [S-1:0][W-1:0] o_rows
);

   logic [LW-1:0] w_m;
   logic [S-1:0]  w_n;

   generate
      if (AE >= BE) begin : g_a_long
         assign w_m = i_a;
         assign w_n = i_b;
      end else begin : g_b_long
         assign w_m = i_b;
         assign w_n = i_a;
      end
   endgenerate

   // Sign-weighted terms are inverted; the constant 1 at bit LW of the last row
   // plus the final-layer correction restore the two's complement result.
   always_comb begin
      o_rows = '0;
      for (int i = 0; i < S - 1; i++) begin
         for (int j = 0; j < LW - 1; j++) o_rows[i][j] = w_m[j] & w_n[i];
         o_rows[i][LW-1] = ~(w_m[LW-1] & w_n[i]);
      end
      for (int j = 0; j < LW - 1; j++) o_rows[S-1][j] = ~(w_m[j] & w_n[S-1]);
      o_rows[S-1][LW-1] = w_m[LW-1] & w_n[S-1];
      o_rows[S-1][LW]   = 1'b1;
   end

endmodule

// File: rtl/mult_bw_pipe.sv
// Fully pipelined signed/unsigned multiplier with valid/ready and a tag sideband.
// One global enable stalls every stage; results leave in acceptance order.
module mult_bw_pipe
   import mult_pkg::*;
#(
   parameter int A_WIDTH   = 24,
   parameter int B_WIDTH   = 24,
   parameter int TAG_WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [A_WIDTH-1:0]           in_a,
   input  logic [B_WIDTH-1:0]           in_b,
   input  logic                         in_a_signed,
   input  logic                         in_b_signed,
   input  logic [TAG_WIDTH-1:0]         in_tag,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [A_WIDTH+B_WIDTH-1:0]   out_p,
   output logic [TAG_WIDTH-1:0]         out_tag
);

   localparam int AE     = A_WIDTH + 1;
   localparam int BE     = B_WIDTH + 1;
   localparam int W      = AE + BE;
   localparam int PW     = A_WIDTH + B_WIDTH;
   localparam int S      = n_rows(A_WIDTH, B_WIDTH);
   localparam int L      = clog2(S);
   localparam int STAGES = lat(A_WIDTH, B_WIDTH) - 1;
   localparam int TOT    = row_off(S, L + 1);
   localparam logic [W-1:0] CORR = (W'(1) << (AE - 1)) + (W'(1) << (BE - 1));

   logic                               w_en;
   logic [STAGES:0]                    r_vld_pipe;
   logic [STAGES:0][TAG_WIDTH-1:0]     r_tag_pipe;
   logic [AE-1:0]                      r_a;
   logic [BE-1:0]                      r_b;
   logic [S-1:0][W-1:0]                w_pp;
   logic [TOT-1:0][W-1:0]              r_tree;
   logic [TOT-1:0][W-1:0]              w_tree_d;
   logic                               w_unused_msb;

   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   mult_bw_pp_gen #(.AE(AE), .BE(BE)) u_pp (
      .i_a    (r_a),
      .i_b    (r_b),
      .o_rows (w_pp)
   );

   assign w_tree_d[S-1:0] = w_pp;

   // Layer k pairs row 2j with row 2j+1 shifted by the span each row now covers.
   generate
      for (genvar k = 1; k <= L; k++) begin : g_lay
         localparam int NIN = rows_at(S, k - 1);
         localparam int NOUT = rows_at(S, k);
         localparam int OI = row_off(S, k - 1);
         localparam int OO = row_off(S, k);
         localparam int SH = 1 << (k - 1);
         for (genvar j = 0; j < NOUT; j++) begin : g_row
            logic [W-1:0] w_sum;
            if (2 * j + 1 < NIN) begin : g_add
               assign w_sum = r_tree[OI+2*j] + (r_tree[OI+2*j+1] << SH);
            end else begin : g_fwd
               assign w_sum = r_tree[OI+2*j];
            end
            if (k == L) begin : g_fin
               assign w_tree_d[OO+j] = w_sum + CORR;
            end else begin : g_mid
               assign w_tree_d[OO+j] = w_sum;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vld_pipe <= '0;
         r_tag_pipe <= '0;
         r_a        <= '0;
         r_b        <= '0;
         r_tree     <= '0;
      end else if (w_en) begin
         r_vld_pipe <= {r_vld_pipe[STAGES-1:0], in_valid};
         r_tag_pipe <= {r_tag_pipe[STAGES-1:0], in_tag};
         r_a        <= {in_a_signed & in_a[A_WIDTH-1], in_a};
         r_b        <= {in_b_signed & in_b[B_WIDTH-1], in_b};
         r_tree     <= w_tree_d;
      end
   end

   // Bits above PW only matter modulo 2^W and are dropped at the output.
   assign w_unused_msb = ^r_tree[TOT-1][W-1:PW];

   assign out_valid = r_vld_pipe[STAGES];
   assign out_tag   = r_tag_pipe[STAGES];
   assign out_p     = r_tree[TOT-1][PW-1:0];

endmodule

// File: tb/tb_mult_bw_pipe.sv
// Directed + scoreboard bench for mult_bw_pipe at 8x6 (latency 5).
module tb_mult_bw_pipe;

   localparam int AW = 8, BW = 6, TW = 4, PW = 14, LATC = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, in_ready;
   logic [AW-1:0] in_a = '0;
   logic [BW-1:0] in_b = '0;
   logic          in_a_signed = 1'b0, in_b_signed = 1'b0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid, out_ready = 1'b1;
   logic [PW-1:0] out_p;
   logic [TW-1:0] out_tag;

   typedef struct packed {
      logic [PW-1:0] p;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t sb[$];
   int n_assert = 0, n_fail = 0, n_tx = 0, n_rx = 0;

   mult_bw_pipe #(.A_WIDTH(AW), .B_WIDTH(BW), .TAG_WIDTH(TW)) dut (
      .clk(clk), .reset(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_a_signed(in_a_signed), .in_b_signed(in_b_signed),
      .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   function automatic logic [PW-1:0] model(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                           input logic as, input logic bs);
      logic [15:0] ea, eb, p;
      ea = {{8{as & a[AW-1]}}, a};
      eb = {{10{bs & b[BW-1]}}, b};
      p  = ea * eb;
      return p[PW-1:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_rx++;
            if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
            else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_p", out_p, e.p);
               chk("sb_tag", out_tag, e.tag);
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back('{p: model(in_a, in_b, in_a_signed, in_b_signed), tag: in_tag});
            n_tx++;
         end
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic as, input logic bs, input logic [TW-1:0] tag);
      in_a = a; in_b = b; in_a_signed = as; in_b_signed = bs; in_tag = tag;
      in_valid = 1'b1;
   endtask

   task automatic set_rand();
      set_op(AW'($urandom), BW'($urandom), 1'($urandom), 1'($urandom), TW'($urandom_range(0, 15)));
   endtask

   task automatic directed(input string nm, input logic [AW-1:0] a, input logic [BW-1:0] b,
                           input logic as, input logic bs, input logic [TW-1:0] tag,
                           input logic [PW-1:0] exp);
      int n;
      set_op(a, b, as, bs, tag);
      cycle();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin
         cycle();
         n++;
      end
      chk({nm, "_lat"}, n, LATC);
      chk({nm, "_p"}, out_p, exp);
      chk({nm, "_tag"}, out_tag, tag);
      cycle();
      chk({nm, "_once"}, out_valid, 0);
   endtask

   initial begin
      int rx0, tx0, n;
      logic acc;
      logic [PW-1:0] fp;
      logic [TW-1:0] ft;
      fp = '0;
      ft = '0;

      #1;
      chk("rst_ov", out_valid, 0);
      chk("rst_p", out_p, 0);
      chk("rst_tag", out_tag, 0);
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_rdy", in_ready, 1);

      directed("t1", 8'h80, 6'h20, 1'b1, 1'b1, 4'd1, 14'd4096);
      directed("t2_uu", 8'hFF, 6'h3F, 1'b0, 1'b0, 4'd2, 14'd16065);
      directed("t2_zero", 8'h00, 6'd37, 1'b1, 1'b1, 4'd3, 14'd0);
      directed("t3_su", 8'hFF, 6'h3F, 1'b1, 1'b0, 4'd4, 14'h3FC1);
      directed("t3_us", 8'hFF, 6'h3F, 1'b0, 1'b1, 4'd5, 14'h3F01);

      // back-to-back random stream
      rx0 = n_rx;
      for (int i = 0; i < 200; i++) begin
         set_rand();
         chk("t4_rdy", in_ready, 1);
         cycle();
         chk("t4_ov", out_valid, (i >= 4));
      end
      in_valid = 1'b0;
      repeat (10) cycle();
      chk("t4_cnt", n_rx - rx0, 200);
      chk("t4_drain", sb.size(), 0);

      // output stall with input still offered
      rx0 = n_rx;
      tx0 = n_tx;
      out_ready = 1'b0;
      set_rand();
      for (int c = 0; c < 10; c++) begin
         #1;
         acc = in_ready;
         chk("t5_rdy", in_ready, (c < 5));
         if (c == 5) begin
            fp = out_p;
            ft = out_tag;
         end
         if (c > 5) begin
            chk("t5_ov", out_valid, 1);
            chk("t5_hold_p", out_p, fp);
            chk("t5_hold_tag", out_tag, ft);
         end
         cycle();
         if (acc) set_rand();
      end
      out_ready = 1'b1;
      cycle();
      set_rand();
      cycle();
      in_valid = 1'b0;
      repeat (12) cycle();
      chk("t5_drain", sb.size(), 0);
      chk("t5_cnt", n_rx - rx0, n_tx - tx0);

      // async reset with ops in flight
      set_op(8'h12, 6'h05, 1'b0, 1'b0, 4'd7);
      cycle();
      set_rand();
      cycle();
      set_rand();
      cycle();
      in_valid = 1'b0;
      n = 3;
      while (!out_valid && n < 15) begin
         cycle();
         n++;
      end
      chk("t6_pre_ov", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("t6_ov", out_valid, 0);
      chk("t6_p", out_p, 0);
      chk("t6_tag", out_tag, 0);
      chk("t6_rdy", in_ready, 1);
      sb.delete();
      cycle();
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("t6_stale", out_valid, 0);
      end
      directed("t6_op", 8'h7F, 6'h1F, 1'b1, 1'b1, 4'hA, 14'd3937);
      chk("final_sb", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
